acc_sequencer: RTL
==================

# acc_sequencer

- Operand/accumulator sequencer for the TRISC datapath.
- Sits directly upstream and downstream of the 4-bit two's-complement adder/subtractor:
  - drives the adder's A, B and C0 (add/subtract select) inputs;
  - captures S, OVR and Cout into a 4-bit accumulator and a status-flag register.
- Accepts one operation at a time from the control unit over a valid/ready handshake and pulses `done` when the result is committed.

## Interface
- `WIDTH`, 4: datapath width. Must equal the adder width; only 4 is supported.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op_valid` in 1: operation request.
- `op_ready` out 1: block can accept an operation.
- `op_code` in 2: 00 LOAD, 01 ADD, 10 SUB, 11 CLR.
- `op_data` in WIDTH: operand.
- `add_a` out WIDTH: adder A, equal to the accumulator.
- `add_b` out WIDTH: adder B, the registered operand.
- `add_c0` out 1: adder C0; 1 for SUB, else 0.
- `add_s` in WIDTH: adder sum.
- `add_ovr` in 1: adder signed overflow.
- `add_cout` in 1: adder carry out.
- `acc` out WIDTH: accumulator.
- `flag_z`, `flag_n`, `flag_c`, `flag_v` out 1 each: zero, negative, carry, overflow.
- `done` out 1: one-cycle commit pulse.

## Operation
**States**
- IDLE: `op_ready`=1.
- EXEC: `op_ready`=0.

**Transitions**
- IDLE→EXEC on `op_valid` & `op_ready`. At that edge, register `op_code`, `op_data` and the sub bit (`op_code`==SUB).
- EXEC→IDLE unconditionally. At that edge, commit `acc` and flags and set `done`.
- `op_valid` during EXEC is ignored and not queued. The requester must hold the request until it sees `op_ready`.

**Adder inputs**
- `add_a`, `add_b`, `add_c0` come straight from registers. They are stable for the whole EXEC cycle; the adder is purely combinational.

**Commit rules**
- LOAD: `acc` ← operand; Z/N from the new value; C=0, V=0.
- CLR: `acc` ← 0000; Z=1, N=0, C=0, V=0.
- ADD/SUB: `acc` ← `add_s`; Z = (`acc`==0); N = `acc`[3]; C = `add_cout`; V = `add_ovr`.
- For SUB, C=1 means no borrow.

**Width rules**
- All arithmetic is modulo 2^4 unless saturation is compiled in (see Configuration).

**Reset**
- Reset values: `acc`=0000, `flag_z`=1, `flag_n`=0, `flag_c`=0, `flag_v`=0, `done`=0, state IDLE.
- `op_ready`=0 while `reset` is high.
- Reset mid-operation (EXEC) aborts it: no commit of the operation result, no `done`. `acc`/flags take their reset values.

## Timing
- Accept edge E0; EXEC during cycle E0→E1; commit at E1.
- `done`=1, the new `acc`/flags, and `op_ready`=1 are all visible in cycle E1→E2.
- A new request can be accepted at E2, giving a throughput of one operation per 2 cycles.
- `done` is high for exactly one cycle per committed operation.
- `acc` and flags change only at a commit edge or a reset edge.

## Configuration
- `ACC_SATURATE_EN` defined:
  - ADD/SUB with `add_ovr`=1 commits 0111 if `add_a`[3]=0, else 1000.
  - V=1, C = `add_cout`, Z/N computed from the saturated value.
- `ACC_SATURATE_EN` undefined: the wrapped `add_s` is always committed.
- LOAD/CLR are unaffected either way.

## Structure
- Shared package `trisc_alu_pkg`:
  - op-code enum typedef (LOAD/ADD/SUB/CLR);
  - `WIDTH` constant;
  - saturation constants `SAT_MAX`=0111 and `SAT_MIN`=1000;
  - state enum typedef.
- One sub-module, `acc_flag_gen`: combinational next-`acc` and next-flag computation (including the saturation option).
- The sequencer holds the FSM and registers.
- The adder is instantiated beside this block at the datapath level, not inside it.

## Test plan
- Reset held 2 cycles then released → `acc`=0000, Z=1, N=C=V=0, `done`=0, `op_ready`=1 in the first cycle after release.
- LOAD 0101 then ADD 0011 → `acc`=1000, N=1, V=1, C=0, Z=0. With `ACC_SATURATE_EN`: `acc`=0111, N=0, V=1.
- LOAD 0011 then SUB 0011 → `add_c0`=1 during EXEC, `acc`=0000, Z=1, C=1, V=0.
- LOAD 0000 then SUB 0001 → `acc`=1111, N=1, C=0, V=0.
- `op_valid` held high with ADD 0001 from `acc`=0000 → accepted every 2nd cycle, `done` pulses each time, `acc` 0001, 0010, 0011; request during EXEC is not double-counted.
- `reset` asserted in the EXEC cycle of ADD 0100 → no `done`, `acc`=0000, Z=1 after the edge.

Source files
------------

// File: rtl/trisc_alu_pkg.sv
// Shared types and constants for the TRISC accumulator datapath.
// Optional saturation is selected with ACC_SATURATE_EN (see acc_flag_gen).
package trisc_alu_pkg;

    localparam int WIDTH = 4;

    localparam logic [WIDTH-1:0] SAT_MAX = 4'b0111;
    localparam logic [WIDTH-1:0] SAT_MIN = 4'b1000;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/acc_flag_gen.sv
// Combinational next-accumulator and next-flag computation for acc_sequencer.
// With ACC_SATURATE_EN defined, signed overflow on ADD/SUB clamps to SAT_MAX/SAT_MIN.
module acc_flag_gen
    import trisc_alu_pkg::*;
(
    input  op_t              i_op,
    input  logic [WIDTH-1:0] i_operand,
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_ovr,
    input  logic             i_cout,
`ifdef ACC_SATURATE_EN
    input  logic             i_acc_neg,
`endif
    output logic [WIDTH-1:0] o_acc,
    output logic             o_z,
    output logic             o_n,
    output logic             o_c,
    output logic             o_v
);

    always_comb begin
        o_acc = i_operand;
        o_c   = 1'b0;
        o_v   = 1'b0;
        case (i_op)
            OP_LOAD: o_acc = i_operand;
            OP_CLR:  o_acc = '0;
            default: begin
                o_acc = i_sum;
                o_c   = i_cout;
                o_v   = i_ovr;
`ifdef ACC_SATURATE_EN
                // Overflow direction follows the sign of the accumulator operand.
                if (i_ovr) begin
                    o_acc = i_acc_neg ? SAT_MIN : SAT_MAX;
                end
`endif
            end
        endcase
        o_z = (o_acc == '0);
        o_n = o_acc[WIDTH-1];
    end

endmodule

// File: rtl/acc_sequencer.sv
// Operand/accumulator sequencer around the external 4-bit adder/subtractor.
// Handshake: an op is taken on a rising edge where op_valid && op_ready; op_ready is high only in IDLE.
module acc_sequencer #(
    parameter int WIDTH = trisc_alu_pkg::WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [1:0]            op_code,
    input  logic [WIDTH-1:0]      op_data,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_c0,
    input  logic [WIDTH-1:0]      add_s,
    input  logic                  add_ovr,
    input  logic                  add_cout,
    output logic [WIDTH-1:0]      acc,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  flag_c,
    output logic                  flag_v,
    output logic                  done,
    output trisc_alu_pkg::state_t dbg_state
);

    import trisc_alu_pkg::*;

    state_t           r_state;
    state_t           w_state_next;
    op_t              r_op;
    logic [WIDTH-1:0] r_operand;
    logic             r_sub;
    logic [WIDTH-1:0] r_acc;
    logic             r_z, r_n, r_c, r_v;
    logic             r_done;

    logic             w_accept;
    logic             w_commit;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_z_next, w_n_next, w_c_next, w_v_next;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        op_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                op_ready = ~reset;
                w_accept = op_valid & ~reset;
                if (w_accept) w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                w_commit     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    acc_flag_gen u_flag_gen (
        .i_op      (r_op),
        .i_operand (r_operand),
        .i_sum     (add_s),
        .i_ovr     (add_ovr),
        .i_cout    (add_cout),
`ifdef ACC_SATURATE_EN
        .i_acc_neg (r_acc[WIDTH-1]),
`endif
        .o_acc     (w_acc_next),
        .o_z       (w_z_next),
        .o_n       (w_n_next),
        .o_c       (w_c_next),
        .o_v       (w_v_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_LOAD;
            r_operand <= '0;
            r_sub     <= 1'b0;
            r_acc     <= '0;
            r_z       <= 1'b1;
            r_n       <= 1'b0;
            r_c       <= 1'b0;
            r_v       <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_commit;
            if (w_accept) begin
                r_op      <= op_t'(op_code);
                r_operand <= op_data;
                r_sub     <= (op_t'(op_code) == OP_SUB);
            end
            if (w_commit) begin
                r_acc <= w_acc_next;
                r_z   <= w_z_next;
                r_n   <= w_n_next;
                r_c   <= w_c_next;
                r_v   <= w_v_next;
            end
        end
    end

    assign add_a     = r_acc;
    assign add_b     = r_operand;
    assign add_c0    = r_sub;
    assign acc       = r_acc;
    assign flag_z    = r_z;
    assign flag_n    = r_n;
    assign flag_c    = r_c;
    assign flag_v    = r_v;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule
